// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM arbiter: FSM states, SDRAM command
// encodings, mode-register value and REU address field helpers.
package sdram_pkg;

  typedef enum logic [3:0] {
    ST_INIT_WAIT,
    ST_INIT_PRE,
    ST_REF1,
    ST_NOP1,
    ST_REF2,
    ST_NOP2,
    ST_INIT_MRS,
    ST_IDLE,
    ST_REF,
    ST_REFNOP,
    ST_ACT,
    ST_RD,
    ST_RW1,
    ST_RW2,
    ST_WR,
    ST_WREC
  } state_e;

  // {nCS, nRAS, nCAS, nRWE}
  typedef logic [3:0] cmd_t;

  localparam cmd_t CMD_NOP   = 4'b0111;
  localparam cmd_t CMD_ACT   = 4'b0011;
  localparam cmd_t CMD_READ  = 4'b0101;
  localparam cmd_t CMD_WRITE = 4'b0100;
  localparam cmd_t CMD_PRE   = 4'b0010;
  localparam cmd_t CMD_REF   = 4'b0001;
  localparam cmd_t CMD_MRS   = 4'b0000;

  // Burst length 1, sequential, CAS latency 2, single-location write.
  localparam logic [12:0] MODE_REG     = 13'h0220;
  localparam logic [12:0] RA_ALL_BANKS = 13'h0400;

  typedef struct packed {
    logic [1:0]  bank;
    logic [12:0] row;
    logic [7:0]  col;
    logic        lane;
  } addr_fields_t;

  function automatic addr_fields_t split_addr(input logic [23:0] addr);
    addr_fields_t f;
    f.bank = addr[23:22];
    f.row  = addr[21:9];
    f.col  = addr[8:1];
    f.lane = addr[0];
    return f;
  endfunction

  // Column address with A10 set so every access auto-precharges.
  function automatic logic [12:0] col_addr(input logic [7:0] col);
    return {2'b00, 1'b1, 2'b00, col};
  endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running auto-refresh interval timer: counts while enabled and emits a
// one-cycle expire pulse every INTERVAL cycles, reloading itself each time.
module sdram_refresh_timer #(
  parameter int unsigned INTERVAL = 62
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [CW-1:0] LAST = CW'(INTERVAL - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d    = cnt_q;
    expire_o = 1'b0;
    if (!en_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d    = '0;
      expire_o = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// REU-to-SDRAM controller: power-up init sequence, periodic auto-refresh and
// single-byte read/write accesses with auto-precharge. All pins are registered.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int unsigned INIT_CYCLES  = 800,
  parameter int unsigned REF_INTERVAL = 62
) (
  input  logic        C8M,
  input  logic        RESET,
  input  logic        Req,
  input  logic        ReqWR,
  input  logic [23:0] Addr,
  input  logic [7:0]  WrData,
  output logic        Ack,
  output logic [7:0]  RdData,
  output logic        InitDone,
  output logic        nCS,
  output logic        nRAS,
  output logic        nCAS,
  output logic        nRWE,
  output logic        CKE,
  output logic [1:0]  RBA,
  output logic [12:0] RA,
  output logic        DQMH,
  output logic        DQML,
  output logic [7:0]  RDout,
  output logic        RDoe,
  input  logic [7:0]  RDin
);

  localparam int unsigned ICW = $clog2(INIT_CYCLES + 1);
  localparam logic [ICW-1:0] INIT_LAST = ICW'(INIT_CYCLES);

  state_e         state_q, state_d;
  logic [ICW-1:0] init_cnt_q, init_cnt_d;
  logic           refpend_q, refpend_d;
  logic           init_done_q, init_done_d;
  logic           ack_q, ack_d;
  logic [7:0]     rddata_q, rddata_d;
  cmd_t           cmd_q, cmd_d;
  logic           cke_q, cke_d;
  logic [1:0]     rba_q, rba_d;
  logic [12:0]    ra_q, ra_d;
  logic           dqmh_q, dqmh_d;
  logic           dqml_q, dqml_d;
  logic [7:0]     rdout_q, rdout_d;
  logic           rdoe_q, rdoe_d;
  logic           ref_expire;
  logic           req_ok;
  addr_fields_t   fields;

  assign fields = split_addr(Addr);
  // The Ack cycle never starts a new access, so a held Req restarts one cycle later.
  assign req_ok = Req && init_done_q && !ack_q;

  sdram_refresh_timer #(
    .INTERVAL (REF_INTERVAL)
  ) u_ref_timer (
    .clk_i    (C8M),
    .rst_i    (RESET),
    .en_i     (init_done_q),
    .expire_o (ref_expire)
  );

  always_ff @(posedge C8M or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_INIT_WAIT;
      init_cnt_q  <= '0;
      refpend_q   <= 1'b0;
      init_done_q <= 1'b0;
      ack_q       <= 1'b0;
      rddata_q    <= 8'h00;
      cmd_q       <= CMD_NOP;
      cke_q       <= 1'b1;
      rba_q       <= 2'b00;
      ra_q        <= 13'h0000;
      dqmh_q      <= 1'b0;
      dqml_q      <= 1'b0;
      rdout_q     <= 8'h00;
      rdoe_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      refpend_q   <= refpend_d;
      init_done_q <= init_done_d;
      ack_q       <= ack_d;
      rddata_q    <= rddata_d;
      cmd_q       <= cmd_d;
      cke_q       <= cke_d;
      rba_q       <= rba_d;
      ra_q        <= ra_d;
      dqmh_q      <= dqmh_d;
      dqml_q      <= dqml_d;
      rdout_q     <= rdout_d;
      rdoe_q      <= rdoe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT_WAIT: begin
        if (init_cnt_q == INIT_LAST) begin
          state_d = ST_INIT_PRE;
        end else begin
          state_d = ST_INIT_WAIT;
        end
      end
      ST_INIT_PRE: state_d = ST_REF1;
      ST_REF1:     state_d = ST_NOP1;
      ST_NOP1:     state_d = ST_REF2;
      ST_REF2:     state_d = ST_NOP2;
      ST_NOP2:     state_d = ST_INIT_MRS;
      ST_INIT_MRS: state_d = ST_IDLE;
      ST_IDLE: begin
        if (refpend_q) begin
          state_d = ST_REF;
        end else if (req_ok) begin
          state_d = ST_ACT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REF:      state_d = ST_REFNOP;
      // A request that lost to refresh is launched straight from REFNOP.
      ST_REFNOP: begin
        if (req_ok) begin
          state_d = ST_ACT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACT: begin
        if (ReqWR) begin
          state_d = ST_WR;
        end else begin
          state_d = ST_RD;
        end
      end
      ST_RD:       state_d = ST_RW1;
      ST_RW1:      state_d = ST_RW2;
      ST_RW2:      state_d = ST_IDLE;
      ST_WR:       state_d = ST_WREC;
      ST_WREC:     state_d = ST_IDLE;
      default:     state_d = ST_INIT_WAIT;
    endcase
  end

  // Pin values are decoded from the next state so they appear in that state's cycle.
  always_comb begin
    cmd_d   = CMD_NOP;
    cke_d   = 1'b1;
    rba_d   = 2'b00;
    ra_d    = 13'h0000;
    dqmh_d  = 1'b0;
    dqml_d  = 1'b0;
    rdout_d = 8'h00;
    rdoe_d  = 1'b0;
    case (state_d)
      ST_INIT_PRE: begin
        cmd_d = CMD_PRE;
        ra_d  = RA_ALL_BANKS;
      end
      ST_REF1, ST_REF2, ST_REF: begin
        cmd_d = CMD_REF;
      end
      ST_INIT_MRS: begin
        cmd_d = CMD_MRS;
        ra_d  = MODE_REG;
      end
      ST_ACT: begin
        cmd_d = CMD_ACT;
        rba_d = fields.bank;
        ra_d  = fields.row;
      end
      ST_RD: begin
        cmd_d  = CMD_READ;
        rba_d  = fields.bank;
        ra_d   = col_addr(fields.col);
        dqml_d = fields.lane;
        dqmh_d = ~fields.lane;
      end
      ST_WR: begin
        cmd_d   = CMD_WRITE;
        rba_d   = fields.bank;
        ra_d    = col_addr(fields.col);
        dqml_d  = fields.lane;
        dqmh_d  = ~fields.lane;
        rdout_d = WrData;
        rdoe_d  = 1'b1;
      end
      default: begin
        cmd_d = CMD_NOP;
      end
    endcase
  end

  always_comb begin
    if (state_q == ST_INIT_WAIT) begin
      init_cnt_d = init_cnt_q + ICW'(1);
    end else begin
      init_cnt_d = '0;
    end

    if (ref_expire) begin
      refpend_d = 1'b1;
    end else if (state_d == ST_REF) begin
      refpend_d = 1'b0;
    end else begin
      refpend_d = refpend_q;
    end

    init_done_d = init_done_q || (state_d == ST_IDLE);
    ack_d       = (state_q == ST_RW2) || (state_q == ST_WREC);

    // CAS latency 2: the READ issued in RD has its data on the bus during RW2.
    if (state_q == ST_RW2) begin
      rddata_d = RDin;
    end else begin
      rddata_d = rddata_q;
    end
  end

  assign Ack      = ack_q;
  assign RdData   = rddata_q;
  assign InitDone = init_done_q;
  assign {nCS, nRAS, nCAS, nRWE} = cmd_q;
  assign CKE      = cke_q;
  assign RBA      = rba_q;
  assign RA       = ra_q;
  assign DQMH     = dqmh_q;
  assign DQML     = dqml_q;
  assign RDout    = rdout_q;
  assign RDoe     = rdoe_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter with a tiny CAS-latency-2
// SDRAM model driven from the per-cycle tick task.
module tb_sdram_arbiter;

  localparam int INIT_CYC = 800;
  localparam int REF_INT  = 62;

  localparam logic [3:0] C_NOP   = 4'b0111;
  localparam logic [3:0] C_ACT   = 4'b0011;
  localparam logic [3:0] C_READ  = 4'b0101;
  localparam logic [3:0] C_WRITE = 4'b0100;
  localparam logic [3:0] C_PRE   = 4'b0010;
  localparam logic [3:0] C_REF   = 4'b0001;
  localparam logic [3:0] C_MRS   = 4'b0000;

  logic        C8M    = 1'b0;
  logic        RESET  = 1'b1;
  logic        Req    = 1'b0;
  logic        ReqWR  = 1'b0;
  logic [23:0] Addr   = 24'h000000;
  logic [7:0]  WrData = 8'h00;
  logic [7:0]  RDin   = 8'h00;
  logic        Ack, InitDone, nCS, nRAS, nCAS, nRWE, CKE, DQMH, DQML, RDoe;
  logic [7:0]  RdData, RDout;
  logic [1:0]  RBA;
  logic [12:0] RA;
  logic [3:0]  cmd;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int i0       = 0;
  int ack_cnt  = 0;

  logic [7:0]  mem [logic [23:0]];
  logic [12:0] open_row [4];
  logic [7:0]  rd_pipe   = 8'h00;
  logic        rd_pipe_v = 1'b0;

  always #5 C8M = ~C8M;

  assign cmd = {nCS, nRAS, nCAS, nRWE};

  sdram_arbiter #(
    .INIT_CYCLES  (INIT_CYC),
    .REF_INTERVAL (REF_INT)
  ) dut (
    .C8M      (C8M),
    .RESET    (RESET),
    .Req      (Req),
    .ReqWR    (ReqWR),
    .Addr     (Addr),
    .WrData   (WrData),
    .Ack      (Ack),
    .RdData   (RdData),
    .InitDone (InitDone),
    .nCS      (nCS),
    .nRAS     (nRAS),
    .nCAS     (nCAS),
    .nRWE     (nRWE),
    .CKE      (CKE),
    .RBA      (RBA),
    .RA       (RA),
    .DQMH     (DQMH),
    .DQML     (DQML),
    .RDout    (RDout),
    .RDoe     (RDoe),
    .RDin     (RDin)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance to the middle of the next cycle and let the SDRAM model react to its pins.
  task automatic tick();
    logic [23:0] key;
    @(negedge C8M);
    cyc++;
    if (Ack === 1'b1) ack_cnt++;
    if (rd_pipe_v) begin
      RDin      = rd_pipe;
      rd_pipe_v = 1'b0;
    end
    key = {RBA, open_row[RBA], RA[7:0], DQML};
    case (cmd)
      C_ACT:   open_row[RBA] = RA;
      C_WRITE: mem[key] = RDout;
      C_READ: begin
        rd_pipe   = mem.exists(key) ? mem[key] : 8'h00;
        rd_pipe_v = 1'b1;
      end
      default: ;
    endcase
  endtask

  task automatic wait_until(input int k);
    while (cyc < i0 + k) tick();
  endtask

  task automatic power_up();
    int bad;
    int acks;
    bad  = 0;
    acks = ack_cnt;
    Req   = 1'b1;
    ReqWR = 1'b1;
    RESET = 1'b0;
    for (int k = 0; k < INIT_CYC; k++) begin
      tick();
      if (cmd !== C_NOP || CKE !== 1'b1 || InitDone !== 1'b0 || RDoe !== 1'b0) bad++;
    end
    check_eq("init_nops", bad, 0);
    tick(); check_eq("init_pre", cmd, C_PRE); check_eq("init_pre_a10", RA[10], 1'b1);
    tick(); check_eq("init_ref1", cmd, C_REF);
    tick(); check_eq("init_nop1", cmd, C_NOP);
    tick(); check_eq("init_ref2", cmd, C_REF);
    tick(); check_eq("init_nop2", cmd, C_NOP);
    tick(); check_eq("init_mrs", cmd, C_MRS); check_eq("init_mrs_ra", RA, 13'h0220);
    check_eq("initdone_low_at_mrs", InitDone, 1'b0);
    Req   = 1'b0;
    ReqWR = 1'b0;
    tick(); check_eq("initdone_rise", InitDone, 1'b1); check_eq("idle_nop", cmd, C_NOP);
    check_eq("no_ack_during_init", ack_cnt - acks, 0);
    i0 = cyc;
  endtask

  initial begin
    int refs;
    int prev;
    int bad;
    int acks;
    mem[24'hC00203] = 8'h5A;

    repeat (3) tick();
    check_eq("rst_cmd", cmd, C_NOP);
    check_eq("rst_cke", CKE, 1'b1);
    check_eq("rst_ba_ra", {RBA, RA}, 15'h0000);
    check_eq("rst_dqm", {DQMH, DQML}, 2'b00);
    check_eq("rst_rd_bus", {RDoe, RDout}, 9'h000);
    check_eq("rst_ack_data", {Ack, RdData, InitDone}, 10'h000);

    power_up();

    // Read of 24'hC00203: bank 3, row 1, column 1, odd byte.
    wait_until(3);
    Req = 1'b1; ReqWR = 1'b0; Addr = 24'hC00203;
    tick(); check_eq("rd_act", cmd, C_ACT); check_eq("rd_act_ba", RBA, 2'd3);
    check_eq("rd_act_row", RA, 13'h0001);
    tick(); check_eq("rd_cmd", cmd, C_READ); check_eq("rd_col", RA, 13'h0401);
    check_eq("rd_dqm", {DQMH, DQML}, 2'b01); check_eq("rd_oe", RDoe, 1'b0);
    tick(); check_eq("rd_rw1_nop", cmd, C_NOP);
    tick(); check_eq("rd_no_early_ack", Ack, 1'b0); check_eq("rd_rw2_dqm", {DQMH, DQML}, 2'b00);
    tick(); check_eq("rd_ack", Ack, 1'b1); check_eq("rd_data", RdData, 8'h5A);
    Req = 1'b0;
    tick(); check_eq("rd_ack_one_cycle", Ack, 1'b0);

    // Write 8'hA5 to address 0, then a read request held through the Ack cycle.
    wait_until(12);
    Req = 1'b1; ReqWR = 1'b1; Addr = 24'h000000; WrData = 8'hA5;
    tick(); check_eq("wr_act", cmd, C_ACT); check_eq("wr_act_ba_ra", {RBA, RA}, 15'h0000);
    tick(); check_eq("wr_cmd", cmd, C_WRITE); check_eq("wr_oe", RDoe, 1'b1);
    check_eq("wr_dout", RDout, 8'hA5); check_eq("wr_col", RA, 13'h0400);
    check_eq("wr_dqm", {DQMH, DQML}, 2'b10);
    tick(); check_eq("wrec_nop", cmd, C_NOP); check_eq("wrec_oe", RDoe, 1'b0);
    check_eq("wrec_no_ack", Ack, 1'b0);
    tick(); check_eq("wr_ack", Ack, 1'b1);
    ReqWR = 1'b0;
    tick(); check_eq("b2b_ignored_in_ack", cmd, C_NOP); check_eq("b2b_ack_low", Ack, 1'b0);
    tick(); check_eq("b2b_act", cmd, C_ACT);
    tick(); check_eq("b2b_read", cmd, C_READ); check_eq("b2b_dqm", {DQMH, DQML}, 2'b10);
    tick(); tick();
    tick(); check_eq("readback_ack", Ack, 1'b1); check_eq("readback_data", RdData, 8'hA5);
    Req = 1'b0;

    // Request arrives in the IDLE cycle where the first refresh is pending.
    wait_until(REF_INT);
    Req = 1'b1; ReqWR = 1'b0; Addr = 24'hC00203;
    tick(); check_eq("col_ref_first", cmd, C_REF);
    tick(); check_eq("col_refnop", cmd, C_NOP);
    tick(); check_eq("col_act", cmd, C_ACT);
    tick(); check_eq("col_read", cmd, C_READ);
    tick(); check_eq("col_no_nominal_ack", Ack, 1'b0);
    tick(); check_eq("col_no_ack_plus1", Ack, 1'b0);
    tick(); check_eq("col_ack_plus2", Ack, 1'b1); check_eq("col_data", RdData, 8'h5A);
    Req = 1'b0;

    // Idle refresh cadence over ten intervals.
    refs = 0;
    bad  = 0;
    prev = i0 + REF_INT + 1;
    wait_until(70);
    for (int k = 0; k < 10 * REF_INT; k++) begin
      tick();
      if (cmd === C_REF) begin
        refs++;
        if (cyc - prev != REF_INT) bad++;
        prev = cyc;
      end
    end
    check_eq("ref_count", refs, 10);
    check_eq("ref_spacing_bad", bad, 0);

    // Reset in RW1 of a read: pins drop to NOP at once and no Ack ever follows.
    Req = 1'b1; ReqWR = 1'b0; Addr = 24'hC00203;
    tick(); check_eq("abort_act", cmd, C_ACT);
    tick(); tick(); check_eq("abort_rw1", cmd, C_NOP);
    acks  = ack_cnt;
    RESET = 1'b1;
    Req   = 1'b0;
    #1;
    check_eq("abort_cmd_nop", cmd, C_NOP);
    check_eq("abort_cke", CKE, 1'b1);
    check_eq("abort_ba_ra", {RBA, RA}, 15'h0000);
    check_eq("abort_clears", {Ack, RdData, InitDone, RDoe, RDout}, 19'h00000);
    repeat (3) tick();
    power_up();
    check_eq("abort_no_ack", ack_cnt - acks, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
